// File: rtl/axis_mac_vec_if.sv
`default_nettype none
// ============================================================================
// Module   : axis_mac_vec_if
// Brief    : Operand stream in, packet-result stream out, for axis_mac_vec.
// Revision : 1.0 - initial release
// ============================================================================
interface axis_mac_vec_if #(
    parameter int LANES = 4,
    parameter int A_W   = 14,
    parameter int B_W   = 14,
    parameter int OUT_W = 28
);
    logic                   s_valid;
    logic                   s_ready;
    logic                   s_last;
    logic [LANES*A_W-1:0]   s_a;
    logic [LANES*B_W-1:0]   s_b;
    logic                   m_valid;
    logic                   m_ready;
    logic [OUT_W-1:0]       m_data;
    logic                   m_sat;

    // slave: the MAC itself; master: the operand source / result sink
    modport slave (
        input  s_valid, s_last, s_a, s_b, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );

    modport master (
        output s_valid, s_last, s_a, s_b, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );
endinterface
`default_nettype wire

// File: rtl/axis_mac_vec.sv
`default_nettype none
// ============================================================================
// Module   : axis_mac_vec
// Brief    : LANES-wide signed fixed-point MAC, one rounded result per packet.
//            Define AXIS_MAC_VEC_SAT_EN to saturate (else results wrap).
// Revision : 1.0 - initial release
// ============================================================================
module axis_mac_vec #(
    parameter int LANES     = 4,
    parameter int INT_A     = 6,
    parameter int FRAC_A    = 8,
    parameter int INT_B     = 6,
    parameter int FRAC_B    = 8,
    parameter int ACC_GUARD = 8,
    parameter int OUT_INT   = 12,
    parameter int OUT_FRAC  = 16
) (
    input  logic            clock,
    input  logic            rstn,
    axis_mac_vec_if.slave   bus
);

    localparam int c_A_W   = INT_A + FRAC_A;
    localparam int c_B_W   = INT_B + FRAC_B;
    localparam int c_PW    = INT_A + INT_B + FRAC_A + FRAC_B;
    localparam int c_SW    = c_PW + $clog2(LANES);
    localparam int c_ACC_W = c_SW + ACC_GUARD;
    localparam int c_OUT_W = OUT_INT + OUT_FRAC;
    localparam int c_SH    = FRAC_A + FRAC_B - OUT_FRAC;
    // formatting width: room for the rounding carry and for the clip bounds
    localparam int c_XW    = (c_ACC_W + 1 > c_OUT_W + 1) ? c_ACC_W + 1 : c_OUT_W + 1;

    logic                       w_en;
    logic signed [c_PW-1:0]     w_prod [LANES];
    logic signed [c_PW-1:0]     r_prod [LANES];
    logic                       r_v1;
    logic                       r_l1;
    logic signed [c_SW-1:0]     w_sum;
    logic signed [c_SW-1:0]     r_sum;
    logic                       r_v2;
    logic                       r_l2;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic signed [c_ACC_W-1:0]  w_acc_next;
    logic signed [c_XW-1:0]     w_fmt_in;
    logic signed [c_XW-1:0]     w_rnd;
    logic [c_OUT_W-1:0]         w_fmt;
    logic                       w_sat;
    logic                       r_m_valid;
    logic [c_OUT_W-1:0]         r_m_data;
    logic                       r_m_sat;

    // a single enable freezes the whole pipeline while a result is stuck
    assign w_en        = !r_m_valid || bus.m_ready;
    assign bus.s_ready = w_en;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_sat   = r_m_sat;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [c_A_W-1:0] w_a;
            logic signed [c_B_W-1:0] w_b;
            assign w_a       = bus.s_a[i*c_A_W +: c_A_W];
            assign w_b       = bus.s_b[i*c_B_W +: c_B_W];
            assign w_prod[i] = c_PW'(w_a) * c_PW'(w_b);
        end
    endgenerate

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= '0;
            end
            r_v1 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_en) begin
            for (int i = 0; i < LANES; i++) begin
                r_prod[i] <= w_prod[i];
            end
            r_v1 <= bus.s_valid;
            r_l1 <= bus.s_last;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + c_SW'(r_prod[i]);
        end
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_sum <= '0;
            r_v2  <= 1'b0;
            r_l2  <= 1'b0;
        end else if (w_en) begin
            r_sum <= w_sum;
            r_v2  <= r_v1;
            r_l2  <= r_l1;
        end
    end

    assign w_acc_next = r_acc + c_ACC_W'(r_sum);
    assign w_fmt_in   = c_XW'(w_acc_next);

    generate
        if (c_SH > 0) begin : g_round
            localparam logic signed [c_XW-1:0] c_ONE = 1;
            localparam logic signed [c_XW-1:0] c_RND = c_ONE << (c_SH - 1);
            assign w_rnd = (w_fmt_in + c_RND) >>> c_SH;
        end else begin : g_no_round
            assign w_rnd = w_fmt_in;
        end
    endgenerate

`ifdef AXIS_MAC_VEC_SAT_EN
    localparam logic signed [c_XW-1:0] c_MAX =
        {{(c_XW-c_OUT_W+1){1'b0}}, {(c_OUT_W-1){1'b1}}};
    localparam logic signed [c_XW-1:0] c_MIN =
        {{(c_XW-c_OUT_W+1){1'b1}}, {(c_OUT_W-1){1'b0}}};
    logic w_hi;
    logic w_lo;
    assign w_hi  = w_rnd > c_MAX;
    assign w_lo  = w_rnd < c_MIN;
    assign w_sat = w_hi || w_lo;
    assign w_fmt = w_hi ? c_OUT_W'(c_MAX) :
                   w_lo ? c_OUT_W'(c_MIN) : c_OUT_W'(w_rnd);
`else
    assign w_sat = 1'b0;
    assign w_fmt = c_OUT_W'(w_rnd);
`endif

    // the last beat seeds the result and clears the accumulator in one step
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            r_acc     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else if (w_en) begin
            if (r_v2 && r_l2) begin
                r_acc     <= '0;
                r_m_valid <= 1'b1;
                r_m_data  <= w_fmt;
                r_m_sat   <= w_sat;
            end else begin
                r_m_valid <= 1'b0;
                if (r_v2) begin
                    r_acc <= w_acc_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/axis_mac_vec.md
Name: axis_mac_vec

Overview:
- Parametrised successor to the single-lane fixed-point MAC.
- Multiplies LANES pairs of signed fixed-point operands per beat and sums the lanes. Accumulates the sums across an AXI-Stream packet (delimited by s_last).
- Emits one rounded, saturated result per packet on a master stream with full valid/ready backpressure.
- Sits between operand-fetch streams and downstream filter/dot-product consumers.

Parameters:
LANES, 4, number of parallel multiplier lanes (>=1)
INT_A, 6, integer bits of operand a, sign included
FRAC_A, 8, fractional bits of operand a
INT_B, 6, integer bits of operand b, sign included
FRAC_B, 8, fractional bits of operand b
ACC_GUARD, 8, extra accumulator headroom bits (packet length)
OUT_INT, 12, integer bits of result, sign included
OUT_FRAC, 16, fractional bits of result; must be <= FRAC_A+FRAC_B

Ports:
clock  in  1  sole clock, rising edge
rstn  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_last  in  1  final beat of packet
s_a  in  LANES*(INT_A+FRAC_A)  signed lane operands a, lane 0 in LSBs
s_b  in  LANES*(INT_B+FRAC_B)  signed lane operands b, lane 0 in LSBs
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  OUT_INT+OUT_FRAC  signed packet result
m_sat  out  1  result was clipped (qualified by m_valid)

Behaviour:
- Clock and reset: one clock, clock. Reset rstn is asynchronous and active-low.
- Reset values: m_valid=0, m_data=0, m_sat=0. All stage valid/last bits=0. Accumulator=0.
- s_ready = !m_valid || m_ready (combinational). Global advance enable en = s_ready. When en=0, every pipeline register holds.
- Widths:
  - Product: PW = INT_A+INT_B+FRAC_A+FRAC_B, with FRAC_A+FRAC_B fractional bits.
  - Lane sum: PW+clog2(LANES).
  - Accumulator: AW = PW+clog2(LANES)+ACC_GUARD, two's-complement, wraps silently.
- Stage 1 (on en): register the LANES full-precision signed products plus v1=s_valid&&s_ready and l1=s_last.
- Stage 2 (on en): register the sign-extended lane sum plus v2=v1 and l2=l1.
- Stage 3 (on en, v2=1):
  - l2=0: acc <= acc+sum.
  - l2=1: m_data <= fmt(acc+sum); m_valid <= 1; acc <= 0. The next packet starts clean, with no dead cycle.
- Output handshake: m_valid clears on m_valid&&m_ready unless a new result loads in the same cycle. m_data and m_sat stay stable while m_valid&&!m_ready.
- Latency: if the last beat is accepted in cycle n, m_valid is high in cycle n+3, absent stalls. Sustained throughput is one beat per cycle. Back-to-back single-beat packets give one result per cycle.
- Bubbles: s_valid=0 cycles insert bubbles. The accumulator holds across them.
- fmt(x):
  - SH = FRAC_A+FRAC_B-OUT_FRAC.
  - If SH>0, round half-up: x' = (x + 2^(SH-1)) >>> SH (arithmetic). If SH=0, x' = x.
  - Clip x' to [-2^(OUT_INT+OUT_FRAC-1), 2^(OUT_INT+OUT_FRAC-1)-1]. m_sat=1 if clipped.
- Single-beat packet (s_last on first beat): result is that beat's lane sum only.
- Reset mid-packet: partial accumulation and in-flight beats are discarded. s_ready=1 on the first cycle after release.
- A beat with s_valid=1 while s_ready=0 is not consumed. The source must hold it (AXI rule).

Optional Feature:
- Macro: AXIS_MAC_VEC_SAT_EN.
- Defined: fmt clips as above and m_sat reports clipping.
- Undefined: fmt truncates x' to OUT_INT+OUT_FRAC LSBs (wrap). m_sat is tied to 0. The clipping comparators are not built.

Test Plan:
- Default params, one beat, all lanes a=0x0100 (1.0), b=0x0200 (2.0), s_last=1, beat accepted in cycle n -> m_valid in cycle n+3, m_data=0x0080000 (8.0), m_sat=0.
- 3-beat packet, all lanes a=-1.5 (0x3E80), b=0.5 (0x0080) -> one result, m_data=-9.0 (0xFF70000), m_valid pulses once.
- All lanes a=b=0x2000 (-32.0), s_last=1:
  - With AXIS_MAC_VEC_SAT_EN: m_data=0x7FFFFFF, m_sat=1.
  - Without it: m_data=0x0000000, m_sat=0.
- Two back-to-back packets, m_ready=0 for 5 cycles once first result valid -> s_ready=0 in the same cycles; m_data is stable. After m_ready=1 both results arrive in order with correct values and no beat is lost.
- Two beats of a 1.0*1.0 packet, then rstn=0 for 1 cycle, then a new 1-beat packet of 1.0*2.0 -> single result 8.0. No residue from the aborted packet.
- OUT_FRAC=8, LANES=1, a=0x0001, b=0x0080 -> m_data=1 (half rounds up). With b=0x3F80 (-0.5) -> m_data=0.
